// File: rtl/counter_sequencer.sv
// counter_sequencer
// Command-driven controller for the neighbouring up/down counter core.
// A (start, target) command is accepted over a valid/ready handshake. The
// block loads the counter, counts in the shorter direction and stops exactly
// on the target. It then returns the final count, the number of enabled
// cycles and an error flag over a response handshake.
//
// Ports
//   aclk, areset            clock; asynchronous active-high reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_start, cmd_target   value to load, value at which counting stops
//   rsp_valid / rsp_ready   response handshake (valid held until accepted)
//   rsp_count               count_out captured at stop
//   rsp_steps               cycles during which enable was high
//   rsp_err                 load timeout or run watchdog fired
//   start_value             to counter start_value (registered)
//   enable                  to counter enable (combinational, RUN only)
//   inc_dec                 to counter inc_dec, 0 = up / 1 = down (registered)
//   count_out               from counter count_out
module counter_sequencer #(
    parameter int WIDTH        = 8,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_count,
    output logic [WIDTH-1:0] rsp_steps,
    output logic             rsp_err,
    output logic [WIDTH-1:0] start_value,
    output logic             enable,
    output logic             inc_dec,
    input  logic [WIDTH-1:0] count_out
);

    localparam int LCW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [LCW-1:0]   LOAD_LAST = LCW'(LOAD_TIMEOUT - 1);
    localparam logic [LCW-1:0]   LOAD_ONE  = LCW'(1);
    localparam logic [LCW-1:0]   LOAD_ZERO = LCW'(0);
    // Half the counter range: the largest distance ever counted.
    localparam logic [WIDTH-1:0] HALF      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] start_q_r;
    logic [WIDTH-1:0] target_q_r;
    logic [WIDTH-1:0] start_value_r;
    logic [WIDTH-1:0] steps_r;
    logic [WIDTH-1:0] rsp_count_r;
    logic [LCW-1:0]   load_cnt_r;
    logic             inc_dec_r;
    logic             rsp_err_r;
    logic             cmd_ready_r;
    logic             rsp_valid_r;

    logic             hs_s;
    logic [WIDTH-1:0] d_up_s;
    logic             go_down_s;
    logic             at_target_s;
    logic             watchdog_s;
    logic             load_match_s;
    logic             load_expire_s;
    logic             enable_s;

    assign hs_s          = cmd_valid & cmd_ready_r;
    assign d_up_s        = cmd_target - cmd_start;
    // A tie at exactly half the range counts up.
    assign go_down_s     = (d_up_s > HALF);
    assign at_target_s   = (count_out == target_q_r);
    assign watchdog_s    = (steps_r == HALF) & ~at_target_s;
    // The first LOAD cycle still shows the pre-reload count, so it is skipped.
    assign load_match_s  = (load_cnt_r != LOAD_ZERO) & (count_out == start_q_r);
    assign load_expire_s = (load_cnt_r == LOAD_LAST);
    // Enable drops in the same cycle the target appears, so no overshoot.
    // The watchdog term keeps steps from passing half the range.
    assign enable_s      = (state_r == ST_RUN) & ~at_target_s & ~watchdog_s;

    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_count   = rsp_count_r;
    assign rsp_steps   = steps_r;
    assign rsp_err     = rsp_err_r;
    assign start_value = start_value_r;
    assign inc_dec     = inc_dec_r;
    assign enable      = enable_s;

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    // An unchanged start_value would not reload the counter.
                    if (cmd_start != start_value_r) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_PRIME;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PRIME: state_nx_s = ST_LOAD;
            ST_LOAD: begin
                if (load_match_s) begin
                    state_nx_s = ST_RUN;
                end else if (load_expire_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (at_target_s | watchdog_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Handshake flags, command latches, counter drive and response capture.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cmd_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            start_q_r     <= ZERO;
            target_q_r    <= ZERO;
            start_value_r <= ZERO;
            inc_dec_r     <= 1'b0;
            steps_r       <= ZERO;
            rsp_count_r   <= ZERO;
            rsp_err_r     <= 1'b0;
            load_cnt_r    <= LOAD_ZERO;
        end else begin
            cmd_ready_r <= (state_nx_s == ST_IDLE);
            rsp_valid_r <= (state_nx_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        start_q_r  <= cmd_start;
                        target_q_r <= cmd_target;
                        inc_dec_r  <= go_down_s;
                        steps_r    <= ZERO;
                        rsp_err_r  <= 1'b0;
                        load_cnt_r <= LOAD_ZERO;
                        if (cmd_start != start_value_r) begin
                            start_value_r <= cmd_start;
                        end else begin
                            start_value_r <= cmd_start ^ ONE;
                        end
                    end
                end
                ST_PRIME: begin
                    start_value_r <= start_q_r;
                    load_cnt_r    <= LOAD_ZERO;
                end
                ST_LOAD: begin
                    if (!load_match_s) begin
                        if (load_expire_s) begin
                            rsp_err_r   <= 1'b1;
                            rsp_count_r <= count_out;
                        end else begin
                            load_cnt_r <= load_cnt_r + LOAD_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (at_target_s) begin
                        rsp_count_r <= count_out;
                    end else if (watchdog_s) begin
                        rsp_err_r   <= 1'b1;
                        rsp_count_r <= count_out;
                    end else begin
                        steps_r <= steps_r + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic       aclk;
    logic       areset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_target;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_count;
    logic [7:0] rsp_steps;
    logic       rsp_err;
    logic [7:0] start_value;
    logic       enable;
    logic       inc_dec;
    logic [7:0] count_out;

    logic       cnt_hold;
    logic       cnt_rst;
    logic [7:0] cnt_prev;

    int check_cnt = 0;
    int fail_cnt  = 0;
    int cyc       = 0;
    int en_cnt    = 0;
    int rise_cyc  = 0;
    bit seen_valid = 1'b0;

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] steps;
        logic       err;
        logic       dir;
        int         lat;
        bit         chk_cnt;
        int         hs;
    } exp_t;

    exp_t sb_q[$];

    counter_sequencer #(.WIDTH(8), .LOAD_TIMEOUT(16)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_start   (cmd_start),
        .cmd_target  (cmd_target),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_count   (rsp_count),
        .rsp_steps   (rsp_steps),
        .rsp_err     (rsp_err),
        .start_value (start_value),
        .enable      (enable),
        .inc_dec     (inc_dec),
        .count_out   (count_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Counter core model: reloads when start_value changes, otherwise steps when enabled.
    assign cnt_rst = areset | cnt_hold;
    always_ff @(posedge aclk or posedge cnt_rst) begin
        if (cnt_rst) begin
            count_out <= 8'd0;
            cnt_prev  <= 8'd0;
        end else begin
            cnt_prev <= start_value;
            if (start_value != cnt_prev) begin
                count_out <= start_value;
            end else if (enable) begin
                count_out <= inc_dec ? count_out - 8'd1 : count_out + 8'd1;
            end
        end
    end

    // Cycle counter used for latency measurement.
    initial begin
        forever begin
            @(posedge aclk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        check_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] c, input logic [7:0] s, input logic e,
                                input logic d, input int lat, input bit cc);
        exp_t x;
        x.cnt = c; x.steps = s; x.err = e; x.dir = d; x.lat = lat; x.chk_cnt = cc; x.hs = 0;
        return x;
    endfunction

    // Response monitor: pops the scoreboard on each response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (enable) en_cnt = en_cnt + 1;
            if (areset) begin
                seen_valid = 1'b0;
            end else if (rsp_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    rise_cyc   = cyc;
                end
                if (rsp_ready) begin
                    seen_valid = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.chk_cnt) chk("rsp_count", rsp_count, e.cnt);
                        chk("rsp_steps", rsp_steps, e.steps);
                        chk("rsp_err", rsp_err, e.err);
                        chk("inc_dec", inc_dec, e.dir);
                        chk("latency", rise_cyc - e.hs, e.lat);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] s, input logic [7:0] t, input bit push,
                            input exp_t e, output int hs);
        int guard;
        exp_t x;
        guard = 0;
        @(negedge aclk);
        cmd_valid  = 1'b1;
        cmd_start  = s;
        cmd_target = t;
        while (!cmd_ready && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        chk("cmd_accept", cmd_ready, 1);
        hs = cyc;
        if (push) begin
            x = e;
            x.hs = cyc;
            sb_q.push_back(x);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_start_value"}, start_value, 0);
        chk({p, "_inc_dec"}, inc_dec, 0);
        chk({p, "_enable"}, enable, 0);
        chk({p, "_cmd_ready"}, cmd_ready, 1);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_count"}, rsp_count, 0);
        chk({p, "_rsp_steps"}, rsp_steps, 0);
        chk({p, "_rsp_err"}, rsp_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int hs;
        int hs2;
        int h;
        int e0;
        int n;
        logic [7:0] cap_c;
        logic [7:0] cap_s;
        logic       cap_e;
        exp_t dummy;

        dummy = mk(8'd0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
        h = 0;
        areset = 1'b1; cmd_valid = 1'b0; cmd_start = 8'd0; cmd_target = 8'd0;
        rsp_ready = 1'b1; cnt_hold = 1'b0;
        repeat (3) @(negedge aclk);
        chk_reset("rst");
        areset = 1'b0;

        // Reset in the middle of a run (prime path, start equals start_value).
        send_cmd(8'd0, 8'd100, 1'b0, dummy, hs);
        repeat (6) @(negedge aclk);
        chk("t1_enable_in_run", enable, 1);
        #2 areset = 1'b1;
        #1 chk_reset("t1");
        @(negedge aclk);
        areset = 1'b0;
        repeat (5) @(negedge aclk);
        chk("t1_no_rsp", rsp_valid, 0);
        chk("t1_cmd_ready", cmd_ready, 1);

        // Simple up count, no prime.
        send_cmd(8'd10, 8'd15, 1'b1, mk(8'd15, 8'd5, 1'b0, 1'b0, 9, 1'b1), hs);
        chk("t2_start_value", start_value, 10);
        wait_drain(50);

        // Repeat start: prime shows start^1 for one cycle.
        send_cmd(8'd10, 8'd8, 1'b1, mk(8'd8, 8'd2, 1'b0, 1'b1, 7, 1'b1), hs);
        chk("t4_sv_primed", start_value, 11);
        @(negedge aclk);
        chk("t4_sv_restored", start_value, 10);
        @(negedge aclk);
        chk("t4_sv_held", start_value, 10);
        wait_drain(50);

        // Wrap-around in both directions and the tie at half range.
        send_cmd(8'd250, 8'd4, 1'b1, mk(8'd4, 8'd10, 1'b0, 1'b0, 14, 1'b1), hs);
        wait_drain(60);
        send_cmd(8'd4, 8'd250, 1'b1, mk(8'd250, 8'd10, 1'b0, 1'b1, 14, 1'b1), hs);
        wait_drain(60);
        send_cmd(8'd0, 8'd128, 1'b1, mk(8'd128, 8'd128, 1'b0, 1'b0, 132, 1'b1), hs);
        wait_drain(200);

        // Load timeout with the counter held in reset.
        cnt_hold = 1'b1;
        @(negedge aclk);
        e0 = en_cnt;
        send_cmd(8'd5, 8'd5, 1'b1, mk(8'd0, 8'd0, 1'b1, 1'b0, 17, 1'b0), hs);
        wait_drain(60);
        chk("t5_enable_never", en_cnt - e0, 0);
        cnt_hold = 1'b0;
        repeat (3) @(negedge aclk);

        // Response backpressure with a queued command.
        rsp_ready = 1'b0;
        send_cmd(8'd20, 8'd23, 1'b1, mk(8'd23, 8'd3, 1'b0, 1'b0, 7, 1'b1), hs);
        fork
            send_cmd(8'd30, 8'd28, 1'b1, mk(8'd28, 8'd2, 1'b0, 1'b1, 6, 1'b1), hs2);
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin
                    @(negedge aclk);
                    n++;
                end
                chk("t6_rsp_valid", rsp_valid, 1);
                cap_c = rsp_count; cap_s = rsp_steps; cap_e = rsp_err;
                chk("t6_cap_count", cap_c, 23);
                for (int i = 0; i < 10; i++) begin
                    @(negedge aclk);
                    chk("t6_hold_valid", rsp_valid, 1);
                    chk("t6_hold_count", rsp_count, cap_c);
                    chk("t6_hold_steps", rsp_steps, cap_s);
                    chk("t6_hold_err", rsp_err, cap_e);
                    chk("t6_cmd_ready_low", cmd_ready, 0);
                end
                rsp_ready = 1'b1;
                h = cyc;
            end
        join
        chk("t6_accept_cycle", hs2, h + 1);
        wait_drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
